// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses aligned to the sync output.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;

    // Resynchronise the pin; sync doubles as the previous value of meta for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            rise <= meta & ~sync;
            fall <= ~meta & sync;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/cs_n/mosi, word deserialiser and buffered serialiser.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int unsigned CNT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [1:0]  MODE        = {CPOL, CPHA};
    localparam bit          LEAD_RISE   = (MODE == MODE0) || (MODE == MODE1);
    localparam bit          SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  buf_data;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_sync;

    logic                  lead_edge, trail_edge;
    logic                  sample_edge, shift_edge;
    logic                  in_frame, word_done;
    logic                  load_now, shift_now;
    logic [DATA_WIDTH-1:0] rx_next;

    sync_edge u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .sync  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as sclk so the sampled bit lines up with the detected edge
    sync_edge u_mosi_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mosi),
        .sync  (mosi_sync),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_sync = ^{sclk_sync, cs_sync, mosi_rise, mosi_fall};

    // Map sclk edges onto sample/shift roles for the configured mode
    assign lead_edge   = LEAD_RISE ? sclk_rise : sclk_fall;
    assign trail_edge  = LEAD_RISE ? sclk_fall : sclk_rise;
    assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

    assign in_frame  = (state == ACTIVE) && !cs_rise;
    assign word_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign rx_next   = {rx_shift[DATA_WIDTH-2:0], mosi_sync};

    // A word enters the tx shifter at frame start (CPHA=0) or at each word boundary
    assign load_now  = ((state == IDLE) && cs_fall && SAMPLE_LEAD)
                     || (in_frame && shift_edge && (SAMPLE_LEAD ? reload : (bit_cnt == '0)));
    assign shift_now = in_frame && shift_edge && !load_now;

    // Frame FSM, shifters, transmit buffer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rx_shift    <= '0;
            tx_shift    <= '0;
            buf_data    <= '0;
            bit_cnt     <= '0;
            reload      <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        reload   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state  <= IDLE;
                        reload <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (word_done) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (SAMPLE_LEAD) begin
                                reload <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_edge && reload) begin
                        reload <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Load from a full buffer, otherwise send zeros and flag the underrun
            if (load_now) begin
                if (!tx_ready) begin
                    tx_shift <= buf_data;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_now) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            // A same-cycle write after an empty load stays buffered for the next word
            if (tx_valid && tx_ready) begin
                buf_data <= tx_data;
                tx_ready <= 1'b0;
            end

            miso    <= (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
            miso_oe <= (state == ACTIVE);
            busy    <= (state == ACTIVE);
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-level SPI master driving a mode 0 and a mode 3 instance.
module tb_spi_slave;

    localparam int unsigned W    = 8;
    localparam int unsigned HALF = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         sclk [2];
    logic         cs_n [2];
    logic         mosi;
    logic [W-1:0] tx_data [2];
    logic         tx_valid [2];
    logic         miso [2];
    logic         miso_oe [2];
    logic         tx_ready [2];
    logic [W-1:0] rx_data [2];
    logic         rx_valid [2];
    logic         busy [2];
    logic         tx_underrun [2];

    int checks = 0;
    int errors = 0;

    int           rxv_cnt [2];
    int           und_cnt [2];
    logic [W-1:0] rx_seen [2][16];

    // Reference model state: buffer occupancy and last received word per instance
    logic         mbuf_full [2];
    logic [W-1:0] mbuf [2];
    logic [W-1:0] mrx [2];

    logic [W-1:0] m_tx [4];
    logic [W-1:0] m_rx [4];

    always #5 clk = ~clk;

    spi_slave #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .reset(reset), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .busy(busy[0]), .tx_underrun(tx_underrun[0])
    );

    spi_slave #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .reset(reset), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .busy(busy[1]), .tx_underrun(tx_underrun[1])
    );

    // Pulse monitor: logs every received word and counts underrun pulses
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rx_valid[d] === 1'b1) begin
                rx_seen[d][rxv_cnt[d] % 16] = rx_data[d];
                rxv_cnt[d]++;
            end
            if (tx_underrun[d] === 1'b1) und_cnt[d]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int d, input string tag);
        chk({tag, " rx_data"}, 32'(rx_data[d]), 32'h0);
        chk({tag, " flags"},
            32'({miso[d], miso_oe[d], tx_ready[d], rx_valid[d], busy[d], tx_underrun[d]}),
            32'(6'b001000));
    endtask

    task automatic write_buf(input int d, input logic [W-1:0] w);
        int n;
        n = 0;
        while (tx_ready[d] !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        chk("write tx_ready before", 32'(tx_ready[d]), 32'h1);
        tx_data[d]  = w;
        tx_valid[d] = 1'b1;
        tick(1);
        tx_valid[d] = 1'b0;
        mbuf[d]      = w;
        mbuf_full[d] = 1'b1;
        chk("write tx_ready after", 32'(tx_ready[d]), 32'h0);
    endtask

    // One half sclk period; optionally performs a buffer write in its first cycle
    task automatic half(input int d, input int b, input int mid_bit, input logic [W-1:0] mid_word);
        if (b == mid_bit) begin
            tx_data[d]  = mid_word;
            tx_valid[d] = 1'b1;
            tick(1);
            tx_valid[d] = 1'b0;
            tick(HALF - 1);
        end else begin
            tick(HALF);
        end
    endtask

    // Bit-level master; CPHA=0 frames end with cs_n high before sclk returns idle
    task automatic xfer(input int d, input int total, input int mid_bit,
                        input logic [W-1:0] mid_word, input int reset_bit);
        logic cp;
        int   k;
        int   i;
        cp = (d == 1);
        for (int j = 0; j < 4; j++) m_rx[j] = '0;
        cs_n[d] = 1'b0;
        tick(8);
        for (int b = 0; b < total; b++) begin
            k = b / W;
            i = W - 1 - (b % W);
            if (b == reset_bit) begin
                reset = 1'b1;
                tick(1);
                check_reset(d, "reset mid-frame");
                reset = 1'b0;
                cs_n[d] = 1'b1;
                tick(8);
                return;
            end
            if (!cp) begin
                mosi = m_tx[k][i];
                half(d, b, mid_bit, mid_word);
                sclk[d] = 1'b1;
                m_rx[k][i] = miso[d];
                if (b == 1) chk("busy in frame", 32'({busy[d], miso_oe[d]}), 32'h3);
                tick(HALF);
                if (b != total - 1) sclk[d] = 1'b0;
            end else begin
                sclk[d] = 1'b0;
                mosi = m_tx[k][i];
                half(d, b, mid_bit, mid_word);
                sclk[d] = 1'b1;
                m_rx[k][i] = miso[d];
                if (b == 1) chk("busy in frame", 32'({busy[d], miso_oe[d]}), 32'h3);
                tick(HALF);
            end
        end
        cs_n[d] = 1'b1;
        tick(4);
        sclk[d] = cp;
        tick(8);
    endtask

    // Predict per-word results from buffer occupancy, run the frame, compare
    task automatic run_frame(input int d, input int total, input int mid_bit,
                             input logic [W-1:0] mid_word, input int reset_bit, input string name);
        logic [W-1:0] exp_m [4];
        int stop, started, complete, exp_und, rx_base, und_base;
        stop     = (reset_bit >= 0 && reset_bit < total) ? reset_bit : total;
        started  = (stop + W - 1) / W;
        complete = total / W;
        exp_und  = 0;
        rx_base  = rxv_cnt[d];
        und_base = und_cnt[d];
        for (int k = 0; k < started; k++) begin
            if (mbuf_full[d]) begin
                exp_m[k]     = mbuf[d];
                mbuf_full[d] = 1'b0;
            end else begin
                exp_m[k] = '0;
                exp_und++;
            end
            if (mid_bit >= 0 && mid_bit < stop && mid_bit / W == k) begin
                mbuf[d]      = mid_word;
                mbuf_full[d] = 1'b1;
            end
        end
        xfer(d, total, mid_bit, mid_word, reset_bit);
        if (stop != total) begin
            mbuf_full[d] = 1'b0;
            mrx[d]       = '0;
            chk({name, " rx_valid count"}, 32'(rxv_cnt[d] - rx_base), 32'h0);
            chk({name, " underrun count"}, 32'(und_cnt[d] - und_base), 32'(exp_und));
            return;
        end
        for (int k = 0; k < complete; k++) begin
            chk($sformatf("%s word%0d to master", name, k), 32'(m_rx[k]), 32'(exp_m[k]));
            chk($sformatf("%s word%0d rx log", name, k), 32'(rx_seen[d][(rx_base + k) % 16]),
                32'(m_tx[k]));
        end
        if (complete > 0) mrx[d] = m_tx[complete - 1];
        chk({name, " rx_valid count"}, 32'(rxv_cnt[d] - rx_base), 32'(complete));
        chk({name, " underrun count"}, 32'(und_cnt[d] - und_base), 32'(exp_und));
        chk({name, " rx_data"}, 32'(rx_data[d]), 32'(mrx[d]));
        chk({name, " tx_ready"}, 32'(tx_ready[d]), 32'(!mbuf_full[d]));
        chk({name, " idle outputs"}, 32'({busy[d], miso_oe[d], miso[d]}), 32'h0);
    endtask

    initial begin
        int d;
        int total;
        int mid;
        reset = 1'b1;
        mosi  = 1'b0;
        for (int j = 0; j < 2; j++) begin
            sclk[j]      = (j == 1);
            cs_n[j]      = 1'b1;
            tx_data[j]   = '0;
            tx_valid[j]  = 1'b0;
            mbuf_full[j] = 1'b0;
            mbuf[j]      = '0;
            mrx[j]       = '0;
        end
        tick(3);
        check_reset(0, "power-on m0");
        check_reset(1, "power-on m3");
        reset = 1'b0;
        tick(4);

        // Mode 0 single word with preload
        write_buf(0, 8'hA5);
        m_tx[0] = 8'h3C;
        run_frame(0, W, -1, 8'h00, -1, "mode0 single");

        // Mode 0 two words, second word written mid-frame
        write_buf(0, 8'h11);
        m_tx[0] = 8'h96;
        m_tx[1] = 8'h69;
        run_frame(0, 2 * W, 3, 8'h22, -1, "mode0 double");

        // Empty buffer underrun
        m_tx[0] = 8'hFF;
        run_frame(0, W, -1, 8'h00, -1, "underrun");

        // Partial word then a clean frame
        m_tx[0] = 8'hE7;
        run_frame(0, 5, -1, 8'h00, -1, "partial");
        write_buf(0, 8'h5A);
        m_tx[0] = 8'hC3;
        run_frame(0, W, -1, 8'h00, -1, "after partial");

        // Mode 3
        write_buf(1, 8'h5A);
        m_tx[0] = 8'hC3;
        run_frame(1, W, -1, 8'h00, -1, "mode3 single");

        // Reset in the middle of a frame with the buffer refilled
        write_buf(0, 8'h3E);
        m_tx[0] = 8'h99;
        m_tx[1] = 8'h66;
        run_frame(0, 2 * W, 2, 8'h77, 4, "reset frame");
        write_buf(0, 8'h81);
        m_tx[0] = 8'h24;
        run_frame(0, W, -1, 8'h00, -1, "after reset");

        // Randomised frames on both modes
        for (int f = 0; f < 40; f++) begin
            d = int'($urandom_range(0, 1));
            total = W * int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) m_tx[k] = 8'($urandom);
            if (!mbuf_full[d] && $urandom_range(0, 1) == 1) write_buf(d, 8'($urandom));
            if ($urandom_range(0, 4) == 0) total = int'($urandom_range(1, total - 1));
            mid = (total > 3 && $urandom_range(0, 1) == 1) ? 3 : -1;
            run_frame(d, total, mid, 8'($urandom), -1, $sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder for the far end of the team's SPI master link. Oversamples the asynchronous `sclk`, `cs_n` and `mosi` pins on the system clock and deserialises received words. In parallel it serialises a word supplied on a ready/valid transmit port onto `miso`. It supports all four CPOL/CPHA modes and back-to-back words within one chip-select frame.

## Interface
- `DATA_WIDTH`, 8: bits per word
- `CPOL`, 0: `sclk` idle level
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge
- `clk`  in  1  system clock; must run at ≥ 8× the `sclk` frequency
- `reset`  in  1  synchronous, active-high
- `sclk`  in  1  serial clock from master, asynchronous
- `cs_n`  in  1  chip select, active-low, asynchronous
- `mosi`  in  1  serial data from master, asynchronous
- `miso`  out  1  serial data to master, MSB first
- `miso_oe`  out  1  output enable; high while selected
- `tx_data`  in  DATA_WIDTH  next word to transmit
- `tx_valid`  in  1  `tx_data` valid
- `tx_ready`  out  1  one-entry transmit buffer empty
- `rx_data`  out  DATA_WIDTH  last complete received word, held until overwritten
- `rx_valid`  out  1  one-cycle pulse; `rx_data` updated
- `busy`  out  1  frame in progress (synchronised `cs_n` low)
- `tx_underrun`  out  1  one-cycle pulse; word started with the buffer empty

## Operation
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0, `tx_underrun`=0. Reset also clears the shift registers, bit counter and buffer, and puts the FSM in IDLE.
- `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchroniser. Edges are detected on the synchronised `sclk` and `cs_n`.
- Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge = the other edge. Leading edge = transition away from the CPOL level.
- Transmit buffer: `tx_valid && tx_ready` captures `tx_data` and clears `tx_ready`. Moving the word to the shift register sets `tx_ready`.
- FSM states: IDLE, ACTIVE.
- IDLE → ACTIVE on the `cs_n` falling edge. Then clear the bit counter and the rx shift register.
- CPHA=0, IDLE → ACTIVE also loads the tx shift register from the buffer.
- ACTIVE sample edge: shift the synchronised `mosi` into the rx shift register and increment the bit counter. At count DATA_WIDTH:
  - copy the word to `rx_data`, pulse `rx_valid`, reset the count to 0;
  - CPHA=0 only: set `reload`.
- ACTIVE shift edge, CPHA=0: if `reload` is set, load the next word and clear `reload`; otherwise shift the tx register left.
- ACTIVE shift edge, CPHA=1: if the bit count is 0, load the next word; otherwise shift left.
- Load rule: take the buffer contents if full. Otherwise load all zeros and pulse `tx_underrun`.
- A buffer write and a load in the same cycle: the load sees the buffer as empty (underrun), and the written word stays in the buffer for the following word.
- `miso` = tx shift register MSB while ACTIVE, else 0. `miso_oe` = ACTIVE.
- `cs_n` rising edge in ACTIVE → IDLE. A partial word is discarded with no `rx_valid`, `reload` is cleared, and the buffer contents are retained.
- Synchronised `sclk` edges seen in IDLE are ignored.
- Reset mid-frame: all outputs reach their reset values on the next edge. The frame resumes only after a fresh `cs_n` falling edge.

## Timing
- Pin-to-action latency is 3 `clk` cycles: 2 synchroniser stages plus the edge register.
- `miso` changes at most 4 `clk` cycles after a master shift edge.
- The master must hold `cs_n` low for ≥ 4 `clk` cycles before the first `sclk` edge.
- `rx_valid` asserts the cycle after the final sample edge is processed, for exactly 1 cycle.
- `tx_underrun` is a 1-cycle pulse coincident with the load.
- `busy` follows synchronised `cs_n` with 2 cycles of latency.
- `mosi` uses the same synchroniser depth as `sclk`, so the sampled bit is aligned to the detected edge.

## Structure
- Package `spi_pkg` holds: state enum (IDLE, ACTIVE); mode constants MODE0–MODE3 as {CPOL, CPHA}; default DATA_WIDTH.
- Sub-module `sync_edge`: 2-flop synchroniser with a registered previous value. Outputs `sync`, `rise`, `fall`, each cleared by `reset`.
- Instantiate `sync_edge` for `sclk` and `cs_n`. Use the `sync` output only for `mosi`.

## Test plan
- Mode 0, preload 0xA5, master sends 0x3C → `rx_data`=0x3C with a single `rx_valid` pulse; master receives 0xA5; `tx_ready` returns to 1.
- Mode 0, 16-bit frame, 0x11 preloaded and 0x22 written mid-word → master receives 0x11 then 0x22; two `rx_valid` pulses (0x96, 0x69 sent); no `tx_underrun`.
- Empty buffer, master sends 0xFF → `tx_underrun` pulses once; master reads 0x00; `rx_data`=0xFF.
- `cs_n` deasserted after 5 bits → no `rx_valid` and `busy` falls. The next full frame then exchanges 0xC3 ↔ 0x5A correctly.
- Mode 3 (CPOL=1, CPHA=1): preload 0x5A, master sends 0xC3 → `rx_data`=0xC3; master receives 0x5A.
- `reset` asserted at bit 4 → next cycle shows all reset values with `tx_ready`=1. A subsequent frame with preload 0x81 returns 0x81 to the master.
